vc_fifo_reader: RTL and testbench
=================================

Name: vc_fifo_reader

Overview:
- Pop-side consumer for the two virtual-channel FIFOs (vc0, vc1); it is the reader for the VC FIFO writers.
- Watches each FIFO's empty flag and head word, and arbitrates round-robin between the channels.
- Routes each popped word to one of two destination FIFOs (d0, d1), selected by a destination bit in the word.
- Honours the destination FIFOs' almost-full pause flags and keeps per-channel pop counters for the bench.

Parameters:
- DATA_SIZE, 10, width of a FIFO word.
- DEST_BIT, 8, index of the word bit that selects the destination (0 = d0, 1 = d1).
- COUNT_SIZE, 5, width of each per-channel pop counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_L  input  1  reset, asynchronous and active-low.
- init  input  1  holds the block in the INIT state while high.
- fifo_empty_vc0  input  1  vc0 FIFO empty.
- fifo_empty_vc1  input  1  vc1 FIFO empty.
- data_vc0  input  DATA_SIZE  vc0 head word; valid whenever fifo_empty_vc0=0.
- data_vc1  input  DATA_SIZE  vc1 head word; valid whenever fifo_empty_vc1=0.
- pause_d0  input  1  d0 FIFO almost-full (backpressure).
- pause_d1  input  1  d1 FIFO almost-full (backpressure).
- pop_vc0  output  1  combinational pop strobe to vc0.
- pop_vc1  output  1  combinational pop strobe to vc1.
- push_d0  output  1  registered push strobe to d0.
- push_d1  output  1  registered push strobe to d1.
- data_d0  output  DATA_SIZE  registered word to d0.
- data_d1  output  DATA_SIZE  registered word to d1.
- idle  output  1  high in the IDLE state.
- pop_count_vc0  output  COUNT_SIZE  words popped from vc0.
- pop_count_vc1  output  COUNT_SIZE  words popped from vc1.

Behaviour:
Reset
- reset_L=0 asynchronously forces: state=INIT, last_grant=1 (so vc0 wins the first tie), push_d*=0, data_d*=0, counters=0.
- While reset is asserted: idle=0 and pops=0.

State machine: INIT, IDLE, ACTIVE.
- INIT -> IDLE on the first clock edge with init=0.
- IDLE -> ACTIVE on an edge where a pop occurred.
- ACTIVE -> IDLE on an edge with no pop, both FIFOs empty, and no push this cycle.
- ACTIVE stays ACTIVE otherwise.
- Any state -> INIT on an edge with init=1.
- In INIT, counters are held at 0.

Eligibility and grant
- elig_vcX = !fifo_empty_vcX && !pause_dY && !init && state!=INIT, where Y = data_vcX[DEST_BIT].
- Grant rule: only one channel eligible -> grant it. Both eligible -> grant the channel != last_grant.
- pop_vcX = grant_X, combinational, in the same cycle as eligibility; at most one pop per cycle.
- init=1 kills pops immediately, in the same cycle.

Datapath (1-cycle latency)
- On the edge ending a pop cycle: data_dY <= data_vcX; push_dY <= 1; the other push <= 0; last_grant <= X; pop_count_vcX <= +1.
- Counters wrap modulo 2^COUNT_SIZE.
- data_d* hold their value when not pushed.
- No pop in a cycle -> both push_d*=0 next cycle.

Boundaries
- Pause is sampled in the pop cycle only. The word in flight is still pushed even if pause rises next cycle; the threshold margin in the destination FIFO absorbs it.
- Both FIFOs empty -> no pops; never pop an empty FIFO.
- Both heads target the same paused destination -> no pop, state unchanged.
- One channel blocked by pause, the other eligible -> the eligible channel is served every cycle; no deadlock.
- Asynchronous reset mid-transfer drops the in-flight push immediately.
- init raised mid-stream: the already-registered push still completes on the next cycle.

Test Plan:
- Reset then init=1 for 2 cycles, both FIFOs non-empty -> no pops, state INIT, idle=0. After init=0: IDLE on the next edge, pops start the following cycle.
- vc0 holds 3 words with DEST_BIT=0, vc1 empty, no pause -> pop_vc0 high 3 cycles; push_d0 high 3 cycles, each 1 cycle later, with matching data; pop_count_vc0=3; idle returns high.
- Both FIFOs non-empty, 4 words each, all to d1 -> pops alternate vc0, vc1, vc0, ... (vc0 first); 8 pushes on d1; both counters =4.
- vc0 head to d0 with pause_d0=1, vc1 head to d1 -> only vc1 popped while pause holds. Release pause -> vc0 served within 2 cycles.
- 32 pops from vc1 with COUNT_SIZE=5 -> pop_count_vc1 wraps to 0.
- reset_L pulled low asynchronously mid-cycle right after a pop edge -> push_d0/d1 drop to 0 immediately; counters=0; state INIT.

Source files
------------

// File: rtl/vc_fifo_reader.sv
// vc_fifo_reader: pop-side consumer for the two virtual-channel FIFOs.
// Picks between vc0 and vc1 round-robin, checks the destination FIFO's
// almost-full flag for the head word, pops it and forwards it one cycle later
// to d0 or d1 as selected by the word's destination bit.
//
// Handshake summary:
//   source side : fifo_empty_vcX=0 means data_vcX is a valid head word;
//                 pop_vcX is the combinational accept, asserted in the same
//                 cycle, and the FIFO advances on the following rising edge.
//   destination : push_dY/data_dY are registered and present the word one
//                 cycle after its pop. pause_dY is an almost-full flag looked
//                 at only in the pop cycle; the destination keeps enough spare
//                 space to take a word that is already in flight.
module vc_fifo_reader #(
    parameter int DATA_SIZE  = 10,
    parameter int DEST_BIT   = 8,
    parameter int COUNT_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic                  fifo_empty_vc0,
    input  logic                  fifo_empty_vc1,
    input  logic [DATA_SIZE-1:0]  data_vc0,
    input  logic [DATA_SIZE-1:0]  data_vc1,
    input  logic                  pause_d0,
    input  logic                  pause_d1,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_SIZE-1:0]  data_d0,
    output logic [DATA_SIZE-1:0]  data_d1,
    output logic                  idle,
    output logic [COUNT_SIZE-1:0] pop_count_vc0,
    output logic [COUNT_SIZE-1:0] pop_count_vc1,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last_grant;   // 1 = vc1 won last, so vc0 wins the next tie
    logic                  r_push_d0;
    logic                  r_push_d1;
    logic [DATA_SIZE-1:0]  r_data_d0;
    logic [DATA_SIZE-1:0]  r_data_d1;
    logic [COUNT_SIZE-1:0] r_count_vc0;
    logic [COUNT_SIZE-1:0] r_count_vc1;

    logic                  w_dest_vc0;
    logic                  w_dest_vc1;
    logic                  w_elig_vc0;
    logic                  w_elig_vc1;
    logic                  w_grant_vc0;
    logic                  w_grant_vc1;
    logic                  w_pop_any;
    logic                  w_sel_dest;
    logic [DATA_SIZE-1:0]  w_sel_word;

    // Eligibility: head present, its destination not paused, block running.
    always_comb begin
        w_dest_vc0 = data_vc0[DEST_BIT];
        w_dest_vc1 = data_vc1[DEST_BIT];
        w_elig_vc0 = !fifo_empty_vc0 && !(w_dest_vc0 ? pause_d1 : pause_d0)
                     && !init && (r_state != ST_INIT);
        w_elig_vc1 = !fifo_empty_vc1 && !(w_dest_vc1 ? pause_d1 : pause_d0)
                     && !init && (r_state != ST_INIT);
    end

    // Round-robin grant: a lone eligible channel wins, a tie goes to the channel that did not win last.
    always_comb begin
        w_grant_vc0 = 1'b0;
        w_grant_vc1 = 1'b0;
        if (w_elig_vc0 && w_elig_vc1) begin
            if (r_last_grant) w_grant_vc0 = 1'b1;
            else              w_grant_vc1 = 1'b1;
        end else begin
            w_grant_vc0 = w_elig_vc0;
            w_grant_vc1 = w_elig_vc1;
        end
        w_pop_any  = w_grant_vc0 | w_grant_vc1;
        w_sel_word = w_grant_vc1 ? data_vc1 : data_vc0;
        w_sel_dest = w_grant_vc1 ? w_dest_vc1 : w_dest_vc0;
    end

    // Next-state logic; init overrides everything and returns to INIT.
    always_comb begin
        w_state_next = r_state;
        if (init) begin
            w_state_next = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT:   w_state_next = ST_IDLE;
                ST_IDLE:   if (w_pop_any) w_state_next = ST_ACTIVE;
                ST_ACTIVE: if (!w_pop_any && fifo_empty_vc0 && fifo_empty_vc1
                               && !r_push_d0 && !r_push_d1)
                               w_state_next = ST_IDLE;
                default:   w_state_next = ST_INIT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_state <= ST_INIT;
        else          r_state <= w_state_next;
    end

    // Datapath: register the popped word toward its destination and remember the winner.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_last_grant <= 1'b1;
            r_push_d0    <= 1'b0;
            r_push_d1    <= 1'b0;
            r_data_d0    <= '0;
            r_data_d1    <= '0;
        end else begin
            r_push_d0 <= w_pop_any && !w_sel_dest;
            r_push_d1 <= w_pop_any &&  w_sel_dest;
            if (w_pop_any && !w_sel_dest) r_data_d0 <= w_sel_word;
            if (w_pop_any &&  w_sel_dest) r_data_d1 <= w_sel_word;
            if (w_pop_any)                r_last_grant <= w_grant_vc1;
        end
    end

    // Per-channel pop counters, held at zero in INIT and wrapping naturally.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count_vc0 <= '0;
            r_count_vc1 <= '0;
        end else if (r_state == ST_INIT) begin
            r_count_vc0 <= '0;
            r_count_vc1 <= '0;
        end else begin
            if (w_grant_vc0) r_count_vc0 <= r_count_vc0 + COUNT_SIZE'(1);
            if (w_grant_vc1) r_count_vc1 <= r_count_vc1 + COUNT_SIZE'(1);
        end
    end

    assign pop_vc0       = w_grant_vc0;
    assign pop_vc1       = w_grant_vc1;
    assign push_d0       = r_push_d0;
    assign push_d1       = r_push_d1;
    assign data_d0       = r_data_d0;
    assign data_d1       = r_data_d1;
    assign idle          = (r_state == ST_IDLE);
    assign pop_count_vc0 = r_count_vc0;
    assign pop_count_vc1 = r_count_vc1;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_vc_fifo_reader.sv
// tb_vc_fifo_reader: directed scenarios for vc_fifo_reader. The two source
// FIFOs are modelled by queues; each scenario task drives stimulus and checks
// the DUT against hand-computed expectations mid-cycle.
module tb_vc_fifo_reader;

    localparam int DW = 10;
    localparam int DB = 8;
    localparam int CW = 5;
    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    logic          clk;
    logic          reset_L;
    logic          init;
    logic          fifo_empty_vc0, fifo_empty_vc1;
    logic [DW-1:0] data_vc0, data_vc1;
    logic          pause_d0, pause_d1;
    logic          pop_vc0, pop_vc1;
    logic          push_d0, push_d1;
    logic [DW-1:0] data_d0, data_d1;
    logic          idle;
    logic [CW-1:0] pop_count_vc0, pop_count_vc1;
    logic [1:0]    dbg_state;

    logic [DW-1:0] vc0_q[$];
    logic [DW-1:0] vc1_q[$];
    int            n_checks;
    int            n_fail;

    vc_fifo_reader #(.DATA_SIZE(DW), .DEST_BIT(DB), .COUNT_SIZE(CW)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .fifo_empty_vc0 (fifo_empty_vc0),
        .fifo_empty_vc1 (fifo_empty_vc1),
        .data_vc0       (data_vc0),
        .data_vc1       (data_vc1),
        .pause_d0       (pause_d0),
        .pause_d1       (pause_d1),
        .pop_vc0        (pop_vc0),
        .pop_vc1        (pop_vc1),
        .push_d0        (push_d0),
        .push_d1        (push_d1),
        .data_d0        (data_d0),
        .data_d1        (data_d1),
        .idle           (idle),
        .pop_count_vc0  (pop_count_vc0),
        .pop_count_vc1  (pop_count_vc1),
        .dbg_state      (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present the queue heads to the DUT.
    task automatic drive_heads();
        fifo_empty_vc0 = (vc0_q.size() == 0);
        fifo_empty_vc1 = (vc1_q.size() == 0);
        data_vc0 = (vc0_q.size() != 0) ? vc0_q[0] : '0;
        data_vc1 = (vc1_q.size() != 0) ? vc1_q[0] : '0;
    endtask

    // Advance one clock; the source FIFOs advance on the edge if popped.
    task automatic clock_pop();
        logic p0, p1;
        #1;
        p0 = pop_vc0;
        p1 = pop_vc1;
        @(posedge clk);
        #1;
        if (p0) begin
            n_checks++;
            if (vc0_q.size() == 0) begin
                $display("FAIL pop_empty_vc0 got pop=1 required no pop of an empty FIFO");
                n_fail++;
            end else void'(vc0_q.pop_front());
        end
        if (p1) begin
            n_checks++;
            if (vc1_q.size() == 0) begin
                $display("FAIL pop_empty_vc1 got pop=1 required no pop of an empty FIFO");
                n_fail++;
            end else void'(vc1_q.pop_front());
        end
        drive_heads();
        #2;
    endtask

    // Reset with empty FIFOs, then release; caller decides init.
    task automatic do_reset(input logic hold_init);
        reset_L  = 1'b0;
        init     = hold_init;
        pause_d0 = 1'b0;
        pause_d1 = 1'b0;
        vc0_q.delete();
        vc1_q.delete();
        drive_heads();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        reset_L  = 1'b0;
        init     = 1'b0;
        pause_d0 = 1'b0;
        pause_d1 = 1'b0;
        vc0_q = {10'h0AA};
        vc1_q = {10'h1BB};
        drive_heads();
        @(posedge clk);
        #3;
        n_checks++;
        if ({pop_vc0, pop_vc1, idle, push_d0, push_d1} !== 5'b0) begin
            $display("FAIL reset_strobes got pop=%b%b idle=%b push=%b%b required all 0",
                     pop_vc0, pop_vc1, idle, push_d0, push_d1);
            n_fail++;
        end
        n_checks++;
        if ({pop_count_vc0, pop_count_vc1, data_d0, data_d1, dbg_state} !== '0) begin
            $display("FAIL reset_regs got cnt=%0d/%0d data=%h/%h state=%0d required zeros",
                     pop_count_vc0, pop_count_vc1, data_d0, data_d1, dbg_state);
            n_fail++;
        end
        init    = 1'b1;
        reset_L = 1'b1;
        #2;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if ({pop_vc0, pop_vc1, idle} !== 3'b000 || dbg_state !== S_INIT) begin
                $display("FAIL init_hold c=%0d got pop=%b%b idle=%b state=%0d required 000 INIT",
                         c, pop_vc0, pop_vc1, idle, dbg_state);
                n_fail++;
            end
            clock_pop();
        end
        init = 1'b0;
        #1;
        n_checks++;
        if ({pop_vc0, pop_vc1} !== 2'b00 || dbg_state !== S_INIT) begin
            $display("FAIL init_release got pop=%b%b state=%0d required 00 INIT",
                     pop_vc0, pop_vc1, dbg_state);
            n_fail++;
        end
        clock_pop();
        n_checks++;
        if (dbg_state !== S_IDLE || idle !== 1'b1 || {pop_vc0, pop_vc1} !== 2'b10) begin
            $display("FAIL init_to_idle got state=%0d idle=%b pop=%b%b required IDLE 1 10",
                     dbg_state, idle, pop_vc0, pop_vc1);
            n_fail++;
        end
        clock_pop();
        n_checks++;
        if (push_d0 !== 1'b1 || data_d0 !== 10'h0AA || {pop_vc0, pop_vc1} !== 2'b01
            || dbg_state !== S_ACTIVE) begin
            $display("FAIL init_first_push got push_d0=%b data=%h pop=%b%b state=%0d required 1 0aa 01 ACTIVE",
                     push_d0, data_d0, pop_vc0, pop_vc1, dbg_state);
            n_fail++;
        end
        clock_pop();
        n_checks++;
        if (push_d1 !== 1'b1 || push_d0 !== 1'b0 || data_d1 !== 10'h1BB
            || pop_count_vc0 !== 5'd1 || pop_count_vc1 !== 5'd1) begin
            $display("FAIL init_second_push got push=%b%b data_d1=%h cnt=%0d/%0d required 01 1bb 1/1",
                     push_d0, push_d1, data_d1, pop_count_vc0, pop_count_vc1);
            n_fail++;
        end
    endtask

    task automatic test_single_channel();
        logic [DW-1:0] w[3];
        logic          e_pop, e_push, e_idle;
        w = '{10'h005, 10'h012, 10'h0A3};
        do_reset(1'b0);
        clock_pop();
        vc0_q = {w[0], w[1], w[2]};
        drive_heads();
        #1;
        for (int c = 0; c < 6; c++) begin
            e_pop  = (c < 3);
            e_push = (c >= 1 && c <= 3);
            e_idle = (c == 0 || c == 5);
            n_checks++;
            if ({pop_vc0, pop_vc1} !== {e_pop, 1'b0}) begin
                $display("FAIL single_pop c=%0d got %b%b required %b0", c, pop_vc0, pop_vc1, e_pop);
                n_fail++;
            end
            n_checks++;
            if ({push_d0, push_d1} !== {e_push, 1'b0}) begin
                $display("FAIL single_push c=%0d got %b%b required %b0", c, push_d0, push_d1, e_push);
                n_fail++;
            end
            if (c >= 1) begin
                n_checks++;
                if (data_d0 !== w[(c >= 3) ? 2 : c-1]) begin
                    $display("FAIL single_data c=%0d got %h required %h", c, data_d0, w[(c >= 3) ? 2 : c-1]);
                    n_fail++;
                end
            end
            n_checks++;
            if (idle !== e_idle) begin
                $display("FAIL single_idle c=%0d got %b required %b", c, idle, e_idle);
                n_fail++;
            end
            if (c == 3) begin
                n_checks++;
                if (pop_count_vc0 !== 5'd3 || pop_count_vc1 !== 5'd0) begin
                    $display("FAIL single_count got %0d/%0d required 3/0", pop_count_vc0, pop_count_vc1);
                    n_fail++;
                end
            end
            clock_pop();
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d[8];
        logic          e0, e1, e_push;
        d = '{10'h101, 10'h111, 10'h102, 10'h112, 10'h103, 10'h113, 10'h104, 10'h114};
        do_reset(1'b0);
        clock_pop();
        vc0_q = {10'h101, 10'h102, 10'h103, 10'h104};
        vc1_q = {10'h111, 10'h112, 10'h113, 10'h114};
        drive_heads();
        #1;
        for (int c = 0; c < 10; c++) begin
            e0     = (c < 8) && (c % 2 == 0);
            e1     = (c < 8) && (c % 2 == 1);
            e_push = (c >= 1 && c <= 8);
            n_checks++;
            if ({pop_vc0, pop_vc1} !== {e0, e1}) begin
                $display("FAIL rr_pop c=%0d got %b%b required %b%b", c, pop_vc0, pop_vc1, e0, e1);
                n_fail++;
            end
            n_checks++;
            if ({push_d0, push_d1} !== {1'b0, e_push}) begin
                $display("FAIL rr_push c=%0d got %b%b required 0%b", c, push_d0, push_d1, e_push);
                n_fail++;
            end
            if (e_push) begin
                n_checks++;
                if (data_d1 !== d[c-1]) begin
                    $display("FAIL rr_data c=%0d got %h required %h", c, data_d1, d[c-1]);
                    n_fail++;
                end
            end
            clock_pop();
        end
        n_checks++;
        if (pop_count_vc0 !== 5'd4 || pop_count_vc1 !== 5'd4) begin
            $display("FAIL rr_count got %0d/%0d required 4/4", pop_count_vc0, pop_count_vc1);
            n_fail++;
        end
    endtask

    task automatic test_pause();
        do_reset(1'b0);
        clock_pop();
        pause_d0 = 1'b1;
        vc0_q = {10'h033};
        vc1_q = {10'h121, 10'h122, 10'h123};
        drive_heads();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({pop_vc0, pop_vc1} !== 2'b01) begin
                $display("FAIL pause_bypass c=%0d got %b%b required 01", c, pop_vc0, pop_vc1);
                n_fail++;
            end
            clock_pop();
        end
        pause_d0 = 1'b0;
        #1;
        n_checks++;
        if ({pop_vc0, pop_vc1} !== 2'b10 || push_d1 !== 1'b1 || data_d1 !== 10'h123) begin
            $display("FAIL pause_release got pop=%b%b push_d1=%b data=%h required 10 1 123",
                     pop_vc0, pop_vc1, push_d1, data_d1);
            n_fail++;
        end
        clock_pop();
        pause_d0 = 1'b1;
        #1;
        n_checks++;
        if (push_d0 !== 1'b1 || data_d0 !== 10'h033 || {pop_vc0, pop_vc1} !== 2'b00) begin
            $display("FAIL pause_inflight got push_d0=%b data=%h pop=%b%b required 1 033 00",
                     push_d0, data_d0, pop_vc0, pop_vc1);
            n_fail++;
        end
        n_checks++;
        if (pop_count_vc0 !== 5'd1 || pop_count_vc1 !== 5'd3) begin
            $display("FAIL pause_count got %0d/%0d required 1/3", pop_count_vc0, pop_count_vc1);
            n_fail++;
        end
        clock_pop();
        n_checks++;
        if ({push_d0, push_d1} !== 2'b00) begin
            $display("FAIL pause_push_drop got %b%b required 00", push_d0, push_d1);
            n_fail++;
        end
        pause_d0 = 1'b0;
    endtask

    task automatic test_both_paused();
        do_reset(1'b0);
        clock_pop();
        pause_d1 = 1'b1;
        vc0_q = {10'h1C1};
        vc1_q = {10'h1C2};
        drive_heads();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({pop_vc0, pop_vc1} !== 2'b00 || dbg_state !== S_IDLE || idle !== 1'b1) begin
                $display("FAIL blocked c=%0d got pop=%b%b state=%0d idle=%b required 00 IDLE 1",
                         c, pop_vc0, pop_vc1, dbg_state, idle);
                n_fail++;
            end
            clock_pop();
        end
        pause_d1 = 1'b0;
        #1;
        n_checks++;
        if ({pop_vc0, pop_vc1} !== 2'b10) begin
            $display("FAIL blocked_release got %b%b required 10", pop_vc0, pop_vc1);
            n_fail++;
        end
        clock_pop();
        n_checks++;
        if ({pop_vc0, pop_vc1} !== 2'b01 || push_d1 !== 1'b1 || data_d1 !== 10'h1C1) begin
            $display("FAIL blocked_next got pop=%b%b push_d1=%b data=%h required 01 1 1c1",
                     pop_vc0, pop_vc1, push_d1, data_d1);
            n_fail++;
        end
        clock_pop();
        n_checks++;
        if (push_d1 !== 1'b1 || data_d1 !== 10'h1C2) begin
            $display("FAIL blocked_last got push_d1=%b data=%h required 1 1c2", push_d1, data_d1);
            n_fail++;
        end
    endtask

    task automatic test_count_wrap();
        do_reset(1'b0);
        clock_pop();
        for (int i = 0; i < 32; i++) vc1_q.push_back(DW'(i));
        drive_heads();
        #1;
        for (int c = 0; c < 32; c++) begin
            n_checks++;
            if ({pop_vc0, pop_vc1} !== 2'b01) begin
                $display("FAIL wrap_pop c=%0d got %b%b required 01", c, pop_vc0, pop_vc1);
                n_fail++;
            end
            if (c == 16) begin
                n_checks++;
                if (pop_count_vc1 !== 5'd16) begin
                    $display("FAIL wrap_mid got %0d required 16", pop_count_vc1);
                    n_fail++;
                end
            end
            clock_pop();
        end
        n_checks++;
        if (pop_count_vc1 !== 5'd0 || pop_count_vc0 !== 5'd0 || vc1_q.size() != 0) begin
            $display("FAIL wrap_count got cnt=%0d/%0d left=%0d required 0/0 0",
                     pop_count_vc0, pop_count_vc1, vc1_q.size());
            n_fail++;
        end
        n_checks++;
        if (push_d0 !== 1'b1 || data_d0 !== 10'd31) begin
            $display("FAIL wrap_last got push_d0=%b data=%h required 1 01f", push_d0, data_d0);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        clock_pop();
        vc0_q = {10'h04C, 10'h04D};
        drive_heads();
        #1;
        clock_pop();
        n_checks++;
        if (push_d0 !== 1'b1 || data_d0 !== 10'h04C || pop_count_vc0 !== 5'd1) begin
            $display("FAIL areset_pre got push_d0=%b data=%h cnt=%0d required 1 04c 1",
                     push_d0, data_d0, pop_count_vc0);
            n_fail++;
        end
        #1;
        reset_L = 1'b0;
        #1;
        n_checks++;
        if ({push_d0, push_d1, pop_vc0, pop_vc1, idle} !== 5'b0 || data_d0 !== '0) begin
            $display("FAIL areset_push got push=%b%b pop=%b%b idle=%b data=%h required all 0",
                     push_d0, push_d1, pop_vc0, pop_vc1, idle, data_d0);
            n_fail++;
        end
        n_checks++;
        if (pop_count_vc0 !== 5'd0 || pop_count_vc1 !== 5'd0 || dbg_state !== S_INIT) begin
            $display("FAIL areset_state got cnt=%0d/%0d state=%0d required 0/0 INIT",
                     pop_count_vc0, pop_count_vc1, dbg_state);
            n_fail++;
        end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    // Scenario sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_pause();
        test_both_paused();
        test_count_wrap();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
